// File: rtl/qcw_adc_capture_if.sv
// CPU register bus used by qcw_adc_capture.
// Request/acknowledge handshake; read data is valid in the acknowledge cycle.
interface qcw_adc_capture_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  logic              mem_valid_i;
  logic              mem_ready_o;
  logic [ADDR_W-1:0] mem_addr_i;
  logic [DATA_W-1:0] mem_wdata_i;
  logic [STRB_W-1:0] mem_wstrb_i;
  logic [DATA_W-1:0] mem_rdata_o;

  modport master (
    output mem_valid_i,
    output mem_addr_i,
    output mem_wdata_i,
    output mem_wstrb_i,
    input  mem_ready_o,
    input  mem_rdata_o
  );

  modport slave (
    input  mem_valid_i,
    input  mem_addr_i,
    input  mem_wdata_i,
    input  mem_wstrb_i,
    output mem_ready_o,
    output mem_rdata_o
  );
endinterface

// File: rtl/qcw_adc_capture.sv
// Serial 10-bit ADC capture for the QCW over-current path, with a CPU register window.
// Optional framing-bit check enabled by defining ADC_FRAME_CHECK_EN.
module qcw_adc_capture #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned CLK_DIV      = 2,
  parameter int unsigned QUIET_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  qcw_adc_capture_if.slave        bus,
  output logic                    adc_cs_n,
  output logic                    adc_sclk,
  input  logic                    adc_sdata,
  output logic [9:0]              adc_dout,
  output logic                    adc_valid
);

  localparam int unsigned DOUT_W         = 10;
  localparam int unsigned HALF_W         = 6;
  localparam int unsigned BIT_W          = 5;
  localparam int unsigned LAST_HALF      = 32;
  localparam int unsigned FIRST_DATA_BIT = 4;
  localparam int unsigned LAST_DATA_BIT  = 13;
  localparam int unsigned CNT_W          = 32;
  localparam int unsigned ERR_W          = 16;
  localparam int unsigned WIN_BYTES      = 16;
  localparam int unsigned DIV_W          = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned QUIET_W        = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;

  localparam logic [DOUT_W-1:0] MIDSCALE = 10'd512;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_QUIET = 2'd3;

  localparam logic [3:0] OFF_CTRL   = 4'd0;
  localparam logic [3:0] OFF_SAMPLE = 4'd4;
  localparam logic [3:0] OFF_COUNT  = 4'd8;
  localparam logic [3:0] OFF_FERR   = 4'd12;

  // Serial engine state
  logic [1:0]         state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [HALF_W-1:0]  half_q, half_d;
  logic [QUIET_W-1:0] quiet_q, quiet_d;
  logic [DOUT_W-1:0]  data_q, data_d;
  logic               bad_q, bad_d;
  logic               sdata_q;
  logic               cs_n_q, cs_n_d;
  logic               sclk_q, sclk_d;
  logic               done_c;
  logic               data_bit_c;

  // Register window state
  logic               enable_q, enable_d;
  logic [DOUT_W-1:0]  sample_q, sample_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               addressed_q;
  logic               mem_ready_q, mem_ready_d;
  logic [31:0]        mem_rdata_q, mem_rdata_d;
  logic [31:0]        offset_c;
  logic [31:0]        rdata_c;
  logic               addressed_c;
  logic               accept_c;
  logic               write_c;
  logic               read_c;
  logic               frame_ok_c;
`ifdef ADC_FRAME_CHECK_EN
  logic [ERR_W-1:0]   ferr_q, ferr_d;
`endif

  assign adc_cs_n        = cs_n_q;
  assign adc_sclk        = sclk_q;
  assign adc_dout        = sample_q;
  assign adc_valid       = valid_q;
  assign bus.mem_ready_o = mem_ready_q;
  assign bus.mem_rdata_o = mem_rdata_q;

  // Received-bit index k = half_q[5:1] while half_q is odd (sclk low phase)
  assign data_bit_c = (half_q[HALF_W-1:1] >= BIT_W'(FIRST_DATA_BIT)) &&
                      (half_q[HALF_W-1:1] <= BIT_W'(LAST_DATA_BIT));

  // Frame sequencer: setup half-period, 16 bit periods, DONE, quiet gap
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    half_d  = half_q;
    quiet_d = quiet_q;
    data_d  = data_q;
    bad_d   = bad_q;
    done_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable_q) begin
          state_d = S_SHIFT;
          div_d   = '0;
          half_d  = '0;
          bad_d   = 1'b0;
        end
      end
      S_SHIFT: begin
        if (div_q == DIV_W'(CLK_DIV - 1)) begin
          div_d = '0;
          if (half_q == HALF_W'(LAST_HALF)) begin
            state_d = S_DONE;
            done_c  = 1'b1;
          end else begin
            half_d = half_q + HALF_W'(1);
            // Leaving an odd (low) half means sclk rises on this edge
            if (half_q[0]) begin
              if (data_bit_c) begin
                data_d = {data_q[DOUT_W-2:0], sdata_q};
              end else begin
                bad_d = bad_q | sdata_q;
              end
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_QUIET;
        quiet_d = '0;
      end
      S_QUIET: begin
        if (quiet_q == QUIET_W'(QUIET_CYCLES - 1)) begin
          state_d = enable_q ? S_SHIFT : S_IDLE;
          div_d   = '0;
          half_d  = '0;
          bad_d   = 1'b0;
        end else begin
          quiet_d = quiet_q + QUIET_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    cs_n_d = (state_d != S_SHIFT);
    sclk_d = ~((state_d == S_SHIFT) & half_d[0]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      half_q  <= '0;
      quiet_q <= '0;
      data_q  <= '0;
      bad_q   <= 1'b0;
      sdata_q <= 1'b0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      half_q  <= half_d;
      quiet_q <= quiet_d;
      data_q  <= data_d;
      bad_q   <= bad_d;
      sdata_q <= adc_sdata;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
    end
  end

`ifdef ADC_FRAME_CHECK_EN
  assign frame_ok_c = ~bad_q;
`else
  assign frame_ok_c = 1'b1;
`endif

  // Bus decode, register updates and sample publication
  always_comb begin
    offset_c    = bus.mem_addr_i - BASE_ADDR;
    addressed_c = bus.mem_valid_i && (bus.mem_addr_i >= BASE_ADDR) &&
                  (offset_c < 32'(WIN_BYTES));
    accept_c    = addressed_c && !addressed_q;
    write_c     = accept_c && (bus.mem_wstrb_i != '0);
    read_c      = accept_c && (bus.mem_wstrb_i == '0);

    sample_d = sample_q;
    valid_d  = 1'b0;
    if (done_c && frame_ok_c) begin
      sample_d = data_q;
      valid_d  = 1'b1;
    end

    enable_d = enable_q;
    if (write_c && (offset_c[3:0] == OFF_CTRL)) begin
      enable_d = bus.mem_wdata_i[0];
    end

    // A clear landing with an increment wins
    count_d = count_q;
    if (write_c && (offset_c[3:0] == OFF_COUNT)) begin
      count_d = '0;
    end else if (valid_d && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end

`ifdef ADC_FRAME_CHECK_EN
    ferr_d = ferr_q;
    if (write_c && (offset_c[3:0] == OFF_FERR)) begin
      ferr_d = '0;
    end else if (done_c && !frame_ok_c && (ferr_q != '1)) begin
      ferr_d = ferr_q + ERR_W'(1);
    end
`endif

    rdata_c = '0;
    case (offset_c[3:0])
      OFF_CTRL:   rdata_c = {31'd0, enable_q};
      OFF_SAMPLE: rdata_c = {22'd0, sample_q};
      OFF_COUNT:  rdata_c = count_q;
`ifdef ADC_FRAME_CHECK_EN
      OFF_FERR:   rdata_c = {16'd0, ferr_q};
`endif
      default:    rdata_c = '0;
    endcase

    mem_ready_d = accept_c;
    mem_rdata_d = read_c ? rdata_c : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enable_q    <= 1'b0;
      sample_q    <= MIDSCALE;
      valid_q     <= 1'b0;
      count_q     <= '0;
      addressed_q <= 1'b0;
      mem_ready_q <= 1'b0;
      mem_rdata_q <= '0;
`ifdef ADC_FRAME_CHECK_EN
      ferr_q      <= '0;
`endif
    end else begin
      enable_q    <= enable_d;
      sample_q    <= sample_d;
      valid_q     <= valid_d;
      count_q     <= count_d;
      addressed_q <= addressed_c;
      mem_ready_q <= mem_ready_d;
      mem_rdata_q <= mem_rdata_d;
`ifdef ADC_FRAME_CHECK_EN
      ferr_q      <= ferr_d;
`endif
    end
  end

  // Only CTRL bit 0 is writable; framing state is dead logic without the check
  logic unused_c;
`ifdef ADC_FRAME_CHECK_EN
  assign unused_c = ^bus.mem_wdata_i[31:1];
`else
  assign unused_c = ^{bus.mem_wdata_i[31:1], bad_q};
`endif

endmodule

// File: tb/tb_qcw_adc_capture.sv
// Directed bench for qcw_adc_capture: frame-vector table plus hand-written corner sequences.
// Build with +define+ADC_FRAME_CHECK_EN to exercise the framing check.
`timescale 1ns/1ps
module tb_qcw_adc_capture;

  localparam int unsigned CLK_DIV = 2;
  localparam int unsigned QUIET   = 8;
  localparam int unsigned CS_LOW  = 33 * CLK_DIV;
  localparam int unsigned PERIOD  = CS_LOW + 1 + QUIET;
  localparam logic [31:0] BASE    = 32'h4000_0100;
  localparam logic [31:0] A_CTRL  = BASE + 32'd0;
  localparam logic [31:0] A_SAMP  = BASE + 32'd4;
  localparam logic [31:0] A_CNT   = BASE + 32'd8;
  localparam logic [31:0] A_FERR  = BASE + 32'd12;
  localparam int unsigned NVEC    = 17;

  typedef struct {
    logic [15:0] frame;
    logic        exp_valid;
    logic [9:0]  exp_dout;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       adc_cs_n, adc_sclk, adc_sdata, adc_valid;
  logic [9:0] adc_dout;

  qcw_adc_capture_if bus_if ();

  qcw_adc_capture #(
    .BASE_ADDR   (BASE),
    .CLK_DIV     (CLK_DIV),
    .QUIET_CYCLES(QUIET)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus_if),
    .adc_cs_n (adc_cs_n),
    .adc_sclk (adc_sclk),
    .adc_sdata(adc_sdata),
    .adc_dout (adc_dout),
    .adc_valid(adc_valid)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // ADC model: shifts the next frame bit out on each falling sclk
  logic [15:0] adc_frame;
  int          bit_idx = 15;
  always @(negedge adc_cs_n) bit_idx = 15;
  always @(negedge adc_sclk) begin
    if (!adc_cs_n && bit_idx >= 0) begin
      adc_sdata = adc_frame[bit_idx];
      bit_idx   = bit_idx - 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at a negedge; drives the request immediately and waits for the acknowledge
  task automatic bus_xfer(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                          output logic [31:0] rdata, output logic acked);
    acked = 1'b0;
    rdata = '0;
    bus_if.mem_valid_i = 1'b1;
    bus_if.mem_addr_i  = addr;
    bus_if.mem_wdata_i = wdata;
    bus_if.mem_wstrb_i = wstrb;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus_if.mem_ready_o) begin
        acked = 1'b1;
        rdata = bus_if.mem_rdata_o;
        break;
      end
    end
    bus_if.mem_valid_i = 1'b0;
    bus_if.mem_wstrb_i = 4'h0;
    @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] d;
    logic        a;
    bus_xfer(addr, data, 4'hF, d, a);
    chk($sformatf("wr ack @%0h", addr), 32'(a), 32'd1);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
    logic [31:0] d;
    logic        a;
    bus_xfer(addr, 32'h0, 4'h0, d, a);
    chk({name, " ack"}, 32'(a), 32'd1);
    chk(name, d, exp);
  endtask

  task automatic wait_fall(output int unsigned t);
    logic ok = 1'b0;
    t = cyc;
    if (!adc_cs_n) ok = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (!adc_cs_n) begin
        ok = 1'b1;
        t  = cyc;
      end
    end
    chk("cs_n fall timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_rise(output int unsigned low_len);
    logic ok = 1'b0;
    low_len = 1;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (adc_cs_n) ok = 1'b1;
      else low_len++;
    end
    chk("cs_n rise timeout", 32'(ok), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  vec_t        vec [NVEC];
  int unsigned t_fall, t_prev, len, exp_cnt, exp_err, exp_ferr;
  logic        skip, flag;
  logic [31:0] d;
  logic        a;

  initial begin
    vec[0] = '{16'b0000_1011001101_00, 1'b1, 10'h2CD};
    for (int k = 0; k < 10; k++) vec[k+1] = '{16'(k * 4), 1'b1, 10'(k)};
    vec[11] = '{16'b0000_1111111111_00, 1'b1, 10'h3FF};
`ifdef ADC_FRAME_CHECK_EN
    vec[12] = '{16'b1000_0000000001_00, 1'b0, 10'h3FF};
    vec[13] = '{16'b0000_0101010101_01, 1'b0, 10'h3FF};
`else
    vec[12] = '{16'b1000_0000000001_00, 1'b1, 10'h001};
    vec[13] = '{16'b0000_0101010101_01, 1'b1, 10'h155};
`endif
    vec[14] = '{16'b0000_0000000000_00, 1'b1, 10'h000};
`ifdef ADC_FRAME_CHECK_EN
    vec[15] = '{16'b0001_1000000000_10, 1'b0, 10'h000};
`else
    vec[15] = '{16'b0001_1000000000_10, 1'b1, 10'h200};
`endif
    vec[16] = '{16'b0000_1000000001_00, 1'b1, 10'h201};

    reset = 1'b1;
    adc_sdata = 1'b0;
    adc_frame = '0;
    bus_if.mem_valid_i = 1'b0;
    bus_if.mem_addr_i  = '0;
    bus_if.mem_wdata_i = '0;
    bus_if.mem_wstrb_i = '0;
    exp_cnt = 0;
    exp_err = 0;
    t_prev  = 0;
    skip    = 1'b0;

    repeat (4) @(negedge clk);
    chk("rst cs_n", 32'(adc_cs_n), 32'd1);
    chk("rst sclk", 32'(adc_sclk), 32'd1);
    chk("rst dout", 32'(adc_dout), 32'h200);
    chk("rst valid", 32'(adc_valid), 32'd0);
    chk("rst ready", 32'(bus_if.mem_ready_o), 32'd0);
    chk("rst rdata", bus_if.mem_rdata_o, 32'd0);
    reset = 1'b0;

    flag = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (adc_cs_n !== 1'b1 || adc_sclk !== 1'b1 || adc_dout !== 10'h200 || adc_valid !== 1'b0 ||
          bus_if.mem_ready_o !== 1'b0 || bus_if.mem_rdata_o !== 32'd0) flag = 1'b0;
    end
    chk("idle 100 cycles", 32'(flag), 32'd1);

    rd(A_SAMP, 32'h200, "SAMPLE after reset");
    rd(A_CTRL, 32'd0, "CTRL after reset");
    rd(A_CNT, 32'd0, "COUNT after reset");
    rd(A_FERR, 32'd0, "FERR after reset");
    bus_xfer(BASE - 32'd4, 32'h0, 4'h0, d, a);
    chk("below window no ack", 32'(a), 32'd0);
    bus_xfer(BASE + 32'd16, 32'h0, 4'h0, d, a);
    chk("above window no ack", 32'(a), 32'd0);

    // Continuous run over the frame table
    adc_frame = vec[0].frame;
    wr(A_CTRL, 32'd1);
    for (int i = 0; i < NVEC; i++) begin
      adc_frame = vec[i].frame;
      wait_fall(t_fall);
      if (i > 0 && !skip) chk($sformatf("period[%0d]", i), t_fall - t_prev, PERIOD);
      wait_rise(len);
      chk($sformatf("cs low len[%0d]", i), len, CS_LOW);
      chk($sformatf("valid[%0d]", i), 32'(adc_valid), 32'(vec[i].exp_valid));
      chk($sformatf("dout[%0d]", i), 32'(adc_dout), 32'(vec[i].exp_dout));
      chk($sformatf("sclk done[%0d]", i), 32'(adc_sclk), 32'd1);
      @(negedge clk);
      chk($sformatf("valid pulse width[%0d]", i), 32'(adc_valid), 32'd0);
      if (vec[i].exp_valid) exp_cnt++;
      else exp_err++;
      skip = 1'b0;
      if (i == 0) begin
        rd(A_CNT, exp_cnt, "COUNT after first frame");
        rd(A_CTRL, 32'd1, "CTRL enabled");
        skip = 1'b1;
      end
      t_prev = t_fall;
    end
`ifdef ADC_FRAME_CHECK_EN
    exp_ferr = exp_err;
`else
    exp_ferr = 0;
`endif
    rd(A_CNT, exp_cnt, "COUNT after table");
    rd(A_FERR, exp_ferr, "FERR after table");

    // Count clear accepted on the same edge as the DONE increment
    adc_frame = 16'b0000_0000000011_00;
    wait_fall(t_fall);
    repeat (CS_LOW - 1) @(negedge clk);
    chk("last shift cycle", 32'(adc_cs_n), 32'd0);
    wr(A_CNT, 32'd0);
    rd(A_CNT, 32'd0, "COUNT clear wins");
    rd(A_SAMP, 32'd3, "SAMPLE after clear frame");
    exp_cnt = 0;

    wait_fall(t_fall);
    wait_rise(len);
    chk("valid after clear", 32'(adc_valid), 32'd1);
    chk("dout after clear", 32'(adc_dout), 32'd3);
    exp_cnt++;
    @(negedge clk);

    // Disable mid-frame: frame finishes, then the engine stops
    adc_frame = 16'b0000_1100110011_00;
    wait_fall(t_fall);
    repeat (CLK_DIV + 5 * 2 * CLK_DIV - 1) @(negedge clk);
    wr(A_CTRL, 32'd0);
    wait_rise(len);
    chk("disable frame valid", 32'(adc_valid), 32'd1);
    chk("disable frame dout", 32'(adc_dout), 32'h333);
    exp_cnt++;
    flag = 1'b1;
    repeat (150) begin
      @(negedge clk);
      if (adc_cs_n !== 1'b1 || adc_valid !== 1'b0 || adc_sclk !== 1'b1) flag = 1'b0;
    end
    chk("stopped after disable", 32'(flag), 32'd1);
    rd(A_CNT, exp_cnt, "COUNT after disable");
    rd(A_CTRL, 32'd0, "CTRL after disable");
    wr(A_SAMP, 32'd0);
    rd(A_SAMP, 32'h333, "SAMPLE read-only");
    wr(A_FERR, 32'd0);
    rd(A_FERR, 32'd0, "FERR after clear");

    // Reset in the middle of a frame
    adc_frame = 16'b0000_1011001101_00;
    wr(A_CTRL, 32'd1);
    wait_fall(t_fall);
    repeat (CLK_DIV + 8 * 2 * CLK_DIV) @(negedge clk);
    chk("mid-frame before reset", 32'(adc_cs_n), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("reset abort cs_n", 32'(adc_cs_n), 32'd1);
    chk("reset abort sclk", 32'(adc_sclk), 32'd1);
    chk("reset abort dout", 32'(adc_dout), 32'h200);
    chk("reset abort valid", 32'(adc_valid), 32'd0);
    reset = 1'b0;
    flag = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (adc_valid !== 1'b0 || adc_cs_n !== 1'b1 || adc_dout !== 10'h200) flag = 1'b0;
    end
    chk("quiet after reset abort", 32'(flag), 32'd1);
    rd(A_CTRL, 32'd0, "CTRL after reset abort");
    rd(A_CNT, 32'd0, "COUNT after reset abort");
    rd(A_SAMP, 32'h200, "SAMPLE after reset abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/qcw_adc_capture.md
Name: qcw_adc_capture

Overview:
Serial ADC front-end for the QCW over-current path. It drives a 10-bit SPI-style ADC with 16-clock frames: 4 leading zeros, 10 data bits MSB first, then 2 trailing zeros. It deserialises each frame and presents the sample on adc_dout, which feeds the OCD comparator directly downstream. A small memory-mapped register window on the CPU bus provides enable, last sample and statistics.

Parameters:
BASE_ADDR, 32'h00000000, byte base address of the register window
CLK_DIV, 2, clk cycles per SCLK half-period (legal range >=1)
QUIET_CYCLES, 8, clk cycles with adc_cs_n high between frames (legal range >=1)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
mem_valid_i  input  1  bus request valid
mem_ready_o  output  1  bus acknowledge, one-cycle pulse
mem_addr_i  input  32  bus byte address
mem_wdata_i  input  32  bus write data
mem_wstrb_i  input  4  byte strobes; nonzero marks a write
mem_rdata_o  output  32  bus read data
adc_cs_n  output  1  ADC chip select, active low
adc_sclk  output  1  ADC serial clock, idles high
adc_sdata  input  1  ADC serial data
adc_dout  output  10  last captured sample, offset-binary, midscale = 512
adc_valid  output  1  one-cycle strobe when adc_dout updates

Behaviour:
- Reset (synchronous, active-high): adc_cs_n=1, adc_sclk=1, adc_dout=512 (midscale, so downstream sees zero current), adc_valid=0, mem_ready_o=0, mem_rdata_o=0; enable, counters and FSM cleared; FSM goes to IDLE. Reset mid-frame aborts the frame immediately; no partial sample is written.
- adc_sdata passes through one register stage before sampling.
- FSM states: IDLE, SHIFT, DONE, QUIET.
- IDLE: cs_n=1, sclk=1. Go to SHIFT when enable=1.
- SHIFT: cs_n=0.
  - First CLK_DIV cycles: sclk high (setup).
  - Then 16 bit periods, each CLK_DIV cycles low followed by CLK_DIV cycles high.
  - A bit is shifted in on the clk edge at which sclk goes low->high.
  - After the 16th bit, go to DONE.
  - CS low time is CLK_DIV*33 cycles (66 at default).
- DONE (1 cycle): cs_n=1, sclk=1. adc_dout <= bits[11:2] of the frame (bit index 15 = first bit received). adc_valid=1 for this cycle only. SAMPLE_COUNT increments, saturating at 32'hFFFFFFFF. Go to QUIET.
- QUIET: cs_n=1 for QUIET_CYCLES cycles. Then go to SHIFT if enable=1, else IDLE.
- Frame period at defaults: 66+1+8 = 75 clk.
- Clearing enable mid-frame: the current frame completes normally, including DONE, then the FSM goes to IDLE.
- Bus interface:
  - The block is addressed when mem_valid_i=1 and BASE_ADDR <= mem_addr_i < BASE_ADDR+16.
  - Each new request is accepted on its first addressed cycle (addressed now, not addressed in the previous cycle).
  - On acceptance: mem_ready_o=1 for exactly one cycle and mem_rdata_o is valid in that same cycle. mem_rdata_o is 0 whenever mem_ready_o=0.
  - Writes require mem_wstrb_i != 0.
  - Unmapped offsets in the window read 0 and ignore writes.
- Registers:
  - +0 CTRL: bit0 = enable, read/write, reset 0.
  - +4 SAMPLE: read returns {22'b0, adc_dout}.
  - +8 SAMPLE_COUNT: read returns the count; any write clears it. If a clear and an increment land in the same cycle, the clear wins (result 0).
  - +12 FRAME_ERR: see Optional Feature.

Optional Feature:
Macro ADC_FRAME_CHECK_EN.
- Defined:
  - In DONE, if any of the 4 leading bits or 2 trailing bits is 1, the frame is bad: adc_dout holds its old value, adc_valid stays 0, SAMPLE_COUNT does not increment, and the saturating 16-bit FRAME_ERR counter increments.
  - FRAME_ERR is readable at +12; any write clears it.
- Not defined: framing bits are ignored, every frame updates adc_dout, and +12 reads 0.

Test Plan:
- Reset, then idle 100 cycles -> adc_cs_n=1, adc_sclk=1, adc_dout=512, adc_valid never 1, SAMPLE reads 0x200.
- Write CTRL=1; ADC model returns 16'b0000_1011001101_00 -> 66 cycles later adc_valid pulses once with adc_dout=0x2CD; SAMPLE_COUNT reads 1; next CS fall occurs 9 cycles after DONE.
- Continuous run of 10 frames with ramp data 0..9 -> 10 valid pulses spaced 75 cycles apart with values 0..9; SAMPLE_COUNT=10; write +8 -> reads 0.
- Write CTRL=0 at bit 5 of a frame -> that frame completes, adc_valid pulses, then cs_n stays 1.
- Assert reset at bit 8 of a frame -> next cycle cs_n=1, sclk=1, adc_dout=512, and no adc_valid pulse.
- ADC_FRAME_CHECK_EN defined, frame 16'b1000_0000000001_00 -> no valid pulse, adc_dout unchanged, FRAME_ERR reads 1, SAMPLE_COUNT unchanged. Same stimulus without the macro -> adc_dout=1 and +12 reads 0.
